ova_frame_sched: RTL
====================

Name: ova_frame_sched

Overview:
- Frame-level scheduler for the camera → async FIFO → LCD path.
- Runs in the camera pixel-clock domain.
- Gates FIFO writes so that only whole frames, aligned to frame start, enter the FIFO.
- Applies optional frame decimation, detects overflow and short frames, and holds off the next frame until the LCD side has drained the FIFO.

Parameters:
- H_ACT, 480, active pixels per line (16-bit words)
- V_ACT, 272, active lines per frame
- FCNT_W, 16, width of the completed-frame counter

Ports:
- clk  in  1  pixel clock (camera i_pclk domain)
- rst_n  in  1  asynchronous active-low reset
- i_en  in  1  capture enable
- i_skip  in  4  frames to drop between captured frames (0 = capture every frame)
- i_vsync  in  1  camera vsync, high pulse between frames
- i_pix  in  16  assembled RGB565 pixel from the receiver
- i_pix_vld  in  1  i_pix valid, one-cycle strobe per pixel
- i_fifo_full  in  1  FIFO full (write domain)
- i_fifo_empty  in  1  FIFO empty, already synchronised into clk domain
- i_clr  in  1  clears sticky error flags
- o_wr_data  out  16  FIFO write data
- o_wr_en  out  1  FIFO write enable
- o_work_en  out  1  frame-in-flight indication to the LCD reader (high CAPTURE..DRAIN)
- o_frame_done  out  1  one-cycle pulse when a captured frame is fully drained
- o_frame_cnt  out  FCNT_W  completed-frame count, wraps
- o_overflow  out  1  sticky: pixel arrived while FIFO full
- o_short  out  1  sticky: vsync arrived before H_ACT*V_ACT pixels were written

Behaviour:
- Interface decided: one clock `clk`, reset `rst_n` asynchronous active-low.
- Reset values: state IDLE; all outputs 0; pixel counter 0; skip counter 0; vsync delay register 0.
- vs_fall = registered vsync & ~i_vsync; vs_rise = ~registered vsync & i_vsync. Both detected one cycle after the input edge.
- States:
  - IDLE: if i_en, go to WAIT_VS.
  - WAIT_VS: if ~i_en, go to IDLE. On vs_fall:
    - if skip_cnt == i_skip: skip_cnt←0, pix_cnt←0, go to CAPTURE;
    - else skip_cnt++, stay in WAIT_VS.
  - CAPTURE: i_en is ignored; the frame always completes.
    - Accepted write = i_pix_vld & ~i_fifo_full; on each accepted write pix_cnt++.
    - When an accepted write makes pix_cnt = H_ACT*V_ACT−1 → H_ACT*V_ACT, go to DRAIN.
    - i_pix_vld & i_fifo_full: drop the pixel, set o_overflow, go to DRAIN (frame aborted).
    - vs_rise before the count completes: set o_short, go to DRAIN.
    - Same-cycle priority: overflow > count-complete > short.
  - DRAIN: no writes. When i_fifo_empty = 1: pulse o_frame_done, o_frame_cnt++, go to WAIT_VS.
    - A vsync seen during DRAIN is ignored. The next capture waits for the following vs_fall.
- o_wr_en = (state==CAPTURE) & i_pix_vld & ~i_fifo_full, combinational, zero latency.
- o_wr_data = i_pix, pass-through.
- o_work_en = (state==CAPTURE)|(state==DRAIN), registered from next-state, so it rises on the cycle CAPTURE is entered.
- Pixels arriving after the terminal count are not written (the state has already left CAPTURE).
- pix_cnt width = clog2(H_ACT*V_ACT+1). o_frame_cnt wraps modulo 2^FCNT_W.
- Sticky flags clear on i_clr. Same-cycle set and i_clr → set wins.
- i_skip is sampled only at vs_fall in WAIT_VS. Changing it mid-frame has no effect on the current frame.
- Reset asserted mid-frame: immediate return to IDLE, o_wr_en low asynchronously.

Test Plan:
- Nominal (H_ACT=8, V_ACT=4, i_skip=0): vsync pulse, then 32 vld pixels → exactly 32 o_wr_en pulses; o_work_en high from the cycle after the vsync fall; with empty=1 afterwards → one o_frame_done pulse, o_frame_cnt=1, o_short=o_overflow=0.
- Decimation (i_skip=2): 6 frames of 32 pixels → writes only in frames 3 and 6; o_frame_cnt=2.
- Overflow: hold i_fifo_full=1 at pixel 10 → 9 writes total, o_overflow=1, state goes to DRAIN; i_clr → flag 0.
- Short frame: vsync rise after 20 pixels → o_short=1, 20 writes, o_frame_done pulses once empty=1.
- Drain hold-off: keep i_fifo_empty=0 across two vsync pulses, then release → done pulse, capture starts on the next vs_fall only; extra 5 pixels past the terminal count produce no writes.
- i_en dropped mid-CAPTURE → the frame completes (32 writes), then IDLE; async reset mid-frame → o_wr_en=0 the same cycle, o_frame_cnt=0.

Source files
------------

// File: rtl/ova_frame_sched.sv
// Frame-level write gate between the camera receiver and the async FIFO.
// Only whole frames that begin at a vsync fall are written; frames can be
// decimated, overflow and short frames raise sticky flags, and the next frame
// is held off until the LCD side reports the FIFO empty.
module ova_frame_sched #(
  parameter int H_ACT  = 480,
  parameter int V_ACT  = 272,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [3:0]        i_skip,
  input  logic              i_vsync,
  input  logic [15:0]       i_pix,
  input  logic              i_pix_vld,
  input  logic              i_fifo_full,
  input  logic              i_fifo_empty,
  input  logic              i_clr,
  output logic [15:0]       o_wr_data,
  output logic              o_wr_en,
  output logic              o_work_en,
  output logic              o_frame_done,
  output logic [FCNT_W-1:0] o_frame_cnt,
  output logic              o_overflow,
  output logic              o_short
);

  localparam int PIX_N = H_ACT * V_ACT;
  localparam int PIX_W = $clog2(PIX_N + 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_N - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DRAIN} state_t;

  state_t           state, state_nxt;
  logic             vs_d;
  logic [PIX_W-1:0] pix_cnt;
  logic [3:0]       skip_cnt;

  logic vs_fall, vs_rise, in_cap, wr_ok, ovf_hit, cnt_done, short_hit;
  logic skip_match, drain_done, take_fall;

  assign vs_fall    = vs_d & ~i_vsync;
  assign vs_rise    = ~vs_d & i_vsync;
  assign in_cap     = (state == CAPTURE);
  assign wr_ok      = in_cap & i_pix_vld & ~i_fifo_full;
  // A pixel that cannot be written aborts the frame; it outranks everything.
  assign ovf_hit    = in_cap & i_pix_vld & i_fifo_full;
  assign cnt_done   = wr_ok & (pix_cnt == PIX_LAST);
  assign short_hit  = in_cap & vs_rise & ~ovf_hit & ~cnt_done;
  assign skip_match = (skip_cnt == i_skip);
  assign drain_done = (state == DRAIN) & i_fifo_empty;
  assign take_fall  = (state == WAIT_VS) & i_en & vs_fall;

  // Writes pass straight through with no added latency.
  assign o_wr_en   = wr_ok;
  assign o_wr_data = i_pix;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; i_en is ignored once a frame is in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_en) state_nxt = WAIT_VS;
      WAIT_VS: begin
        if (!i_en)                      state_nxt = IDLE;
        else if (vs_fall && skip_match) state_nxt = CAPTURE;
      end
      CAPTURE: if (ovf_hit || cnt_done || vs_rise) state_nxt = DRAIN;
      DRAIN:   if (i_fifo_empty) state_nxt = WAIT_VS;
      default: state_nxt = IDLE;
    endcase
  end

  // Edge detect, counters, frame bookkeeping and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d         <= 1'b0;
      pix_cnt      <= '0;
      skip_cnt     <= '0;
      o_work_en    <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= '0;
      o_overflow   <= 1'b0;
      o_short      <= 1'b0;
    end else begin
      vs_d         <= i_vsync;
      o_work_en    <= (state_nxt == CAPTURE) || (state_nxt == DRAIN);
      o_frame_done <= drain_done;
      if (drain_done) o_frame_cnt <= o_frame_cnt + FCNT_W'(1);
      if (take_fall) begin
        if (skip_match) begin
          skip_cnt <= '0;
          pix_cnt  <= '0;
        end else begin
          skip_cnt <= skip_cnt + 4'd1;
        end
      end
      if (wr_ok) pix_cnt <= pix_cnt + PIX_W'(1);
      if (ovf_hit)    o_overflow <= 1'b1;
      else if (i_clr) o_overflow <= 1'b0;
      if (short_hit)  o_short <= 1'b1;
      else if (i_clr) o_short <= 1'b0;
    end
  end

endmodule
